// File: rtl/hkspi_responder.sv
// hkspi_responder: housekeeping SPI responder (SPI mode 0). It turns serial frames of
// command / address / data bytes into byte-wide register write and read strobes.
// The SPI pins are asynchronous and are sampled through 2-flop synchronizers.
// Optional build macro HKSPI_NBYTE_EN: command bits [5:3] give a fixed data byte count
// (0 = stream). Without it those bits are ignored and every frame streams.

module hkspi_responder #(
  parameter logic DEFAULT_SDO_OE = 1'b0
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sck,
  input  logic       csb,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCmd    = 3'd1;
  localparam logic [2:0] StAddr   = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StIgnore = 3'd4;

  // Synchronizer taps: [0] metastable, [1] synchronized, [2] previous (edge detect)
  logic [2:0] sck_q, csb_q, vld_q;
  logic [1:0] sdi_q;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shin_q, shin_d;
  logic [7:0] shout_q, shout_d;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic       inc_q, inc_d, cap_q, cap_d;
  logic       sdo_q, sdo_d, oe_q, oe_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       we_q, we_d, re_q, re_d;
`ifdef HKSPI_NBYTE_EN
  logic [2:0] nbyte_q, nbyte_d;
  logic [2:0] bcnt_q, bcnt_d;
`endif

  logic       sck_rise, sck_fall, csb_fall, csb_hi, sdi_s, byte_done;
  logic [7:0] byte_val, ld_src;

  // Synchronize the raw SPI pins into the wb_clk_i domain
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck_q <= 3'b000;
      csb_q <= 3'b111;
      sdi_q <= 2'b00;
      vld_q <= 3'b000;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      csb_q <= {csb_q[1:0], csb};
      sdi_q <= {sdi_q[0], sdi};
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  // vld_q keeps a csb held low across reset from looking like a fresh frame start
  assign csb_fall  = ~csb_q[1] & csb_q[2] & vld_q[2];
  assign csb_hi    = csb_q[1];
  assign sdi_s     = sdi_q[1];
  assign byte_val  = {shin_q[6:0], sdi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  // Read data captured this cycle must be usable by a coincident sck fall
  assign ld_src    = cap_q ? reg_rdata : shout_q;

  // Frame decode, register strobes and serial output shifting
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shin_d    = shin_q;
    shout_d   = ld_src;
    wr_d      = wr_q;
    rd_d      = rd_q;
    inc_d     = 1'b0;
    cap_d     = re_q;
    sdo_d     = sdo_q;
    oe_d      = oe_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
`ifdef HKSPI_NBYTE_EN
    nbyte_d   = nbyte_q;
    bcnt_d    = bcnt_q;
`endif
    if (state_q == StIdle) begin
      if (csb_fall) begin
        state_d   = StCmd;
        bit_cnt_d = 3'd0;
      end
    end else if (csb_hi) begin
      // Abort wins over a coincident sck rise; a partial byte is dropped
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      sdo_d     = 1'b0;
      cap_d     = 1'b0;
    end else begin
      if (sck_rise && (state_q != StIgnore)) begin
        shin_d    = byte_val;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (inc_q) begin
        addr_d = addr_q + 8'd1;
        re_d   = rd_q;
      end
      case (state_q)
        StCmd: begin
          if (byte_done) begin
            wr_d    = byte_val[7];
            rd_d    = byte_val[6];
            state_d = (byte_val[7:6] == 2'b00) ? StIgnore : StAddr;
`ifdef HKSPI_NBYTE_EN
            nbyte_d = byte_val[5:3];
            bcnt_d  = 3'd0;
`endif
          end
        end
        StAddr: begin
          if (byte_done) begin
            addr_d  = byte_val;
            re_d    = rd_q;
            state_d = StData;
          end
        end
        StData: begin
          if (byte_done) begin
            if (wr_q) begin
              wdata_d = byte_val;
              we_d    = 1'b1;
            end
            inc_d = 1'b1;
`ifdef HKSPI_NBYTE_EN
            bcnt_d = bcnt_q + 3'd1;
            if ((nbyte_q != 3'd0) && ((bcnt_q + 3'd1) == nbyte_q)) begin
              inc_d   = 1'b0;
              state_d = StIgnore;
            end
`endif
          end
          if (sck_fall && rd_q) begin
            oe_d    = 1'b1;
            sdo_d   = ld_src[7];
            shout_d = {ld_src[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Control and datapath state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shin_q    <= 8'h00;
      shout_q   <= 8'h00;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      inc_q     <= 1'b0;
      cap_q     <= 1'b0;
      sdo_q     <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
`ifdef HKSPI_NBYTE_EN
      nbyte_q   <= 3'd0;
      bcnt_q    <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shin_q    <= shin_d;
      shout_q   <= shout_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      inc_q     <= inc_d;
      cap_q     <= cap_d;
      sdo_q     <= sdo_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
`ifdef HKSPI_NBYTE_EN
      nbyte_q   <= nbyte_d;
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign sdo       = sdo_q;
  assign sdo_oe    = oe_q ? 1'b1 : DEFAULT_SDO_OE;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = (state_q == StAddr) || (state_q == StData);

endmodule

// File: tb/tb_hkspi_responder.sv
// tb_hkspi_responder: directed bench for hkspi_responder. Write-type frames come from
// a vector table; read, read-write and reset-abort cases are hand-written sequences.
// Define HKSPI_NBYTE_EN for both bench and RTL to check the fixed byte-count mode.

module tb_hkspi_responder;

  localparam int H = 4;  // sck half period in wb_clk_i cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       csb = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo, sdo_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] we_a[$], we_d[$], re_a[$];
  int         we_c[$], re_c[$];
  logic       oe_seen = 1'b0;

  typedef struct packed {
    logic [3:0]  nb;
    logic [47:0] bytes;
    logic [3:0]  tail_n;
    logic [7:0]  tail_v;
    logic [1:0]  n_we;
    logic [47:0] exp_we;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  hkspi_responder #(.DEFAULT_SDO_OE(1'b0)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .sck      (sck),
    .csb      (csb),
    .sdi      (sdi),
    .sdo      (sdo),
    .sdo_oe   (sdo_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    if (a == 8'h03) return 8'h11;
    if (a == 8'h04) return 8'h5A;
    return a ^ 8'hA5;
  endfunction

  // Register-file model and strobe log; data valid the cycle after reg_re
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_d.push_back(reg_wdata);
      we_c.push_back(cyc);
    end
    if (reg_re) begin
      re_a.push_back(reg_addr);
      re_c.push_back(cyc);
      reg_rdata = mem_rd(reg_addr);
    end
    if (sdo_oe) oe_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    we_a.delete(); we_d.delete(); we_c.delete();
    re_a.delete(); re_c.delete();
    oe_seen = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic r);
    sdi = b;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    r = sdo;
    repeat (H) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) send_bit(v[i], r[i]);
  endtask

  task automatic end_frame();
    repeat (H) @(negedge clk);
    csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    logic [47:0] bs;
    logic [7:0]  tv;
    logic [7:0]  r;
    logic        b;
    bs = v.bytes;
    tv = v.tail_v;
    clear_mon();
    csb = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < int'(v.nb); i++) send_byte(bs[47-8*i -: 8], r);
    for (int i = 0; i < int'(v.tail_n); i++) send_bit(tv[7-i], b);
    end_frame();
  endtask

  task automatic check_frame(input int idx, input vec_t v);
    logic [47:0] ew;
    ew = v.exp_we;
    chk($sformatf("v%0d we_count", idx), we_a.size(), 32'(v.n_we));
    for (int j = 0; j < int'(v.n_we); j++) begin
      if (j < we_a.size()) begin
        chk($sformatf("v%0d we%0d_addr", idx, j), 32'(we_a[j]), 32'(ew[47-16*j -: 8]));
        chk($sformatf("v%0d we%0d_data", idx, j), 32'(we_d[j]), 32'(ew[39-16*j -: 8]));
      end
    end
    chk($sformatf("v%0d re_count", idx), re_a.size(), 0);
    chk($sformatf("v%0d oe_seen", idx), 32'(oe_seen), 0);
    chk($sformatf("v%0d busy_after", idx), 32'(busy), 0);
  endtask

  initial begin
    logic [7:0]  r;
    logic        b;
    logic [15:0] rx;

    vecs[0] = '{nb: 4'd3, bytes: {8'h80, 8'h13, 8'h66, 24'h0}, tail_n: 4'd0, tail_v: 8'h00,
                n_we: 2'd1, exp_we: {8'h13, 8'h66, 32'h0}};
    vecs[1] = '{nb: 4'd4, bytes: {8'h80, 8'hFF, 8'h76, 8'h06, 16'h0}, tail_n: 4'd0,
                tail_v: 8'h00, n_we: 2'd2, exp_we: {8'hFF, 8'h76, 8'h00, 8'h06, 16'h0}};
    vecs[2] = '{nb: 4'd2, bytes: {8'h80, 8'h13, 32'h0}, tail_n: 4'd5, tail_v: 8'hA8,
                n_we: 2'd0, exp_we: 48'h0};
    vecs[3] = '{nb: 4'd3, bytes: {8'h80, 8'h13, 8'h06, 24'h0}, tail_n: 4'd0, tail_v: 8'h00,
                n_we: 2'd1, exp_we: {8'h13, 8'h06, 32'h0}};
    vecs[4] = '{nb: 4'd3, bytes: {8'h00, 8'h55, 8'h77, 24'h0}, tail_n: 4'd0, tail_v: 8'h00,
                n_we: 2'd0, exp_we: 48'h0};
`ifdef HKSPI_NBYTE_EN
    vecs[5] = '{nb: 4'd5, bytes: {8'h90, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h00}, tail_n: 4'd0,
                tail_v: 8'h00, n_we: 2'd2, exp_we: {8'h10, 8'hA1, 8'h11, 8'hB2, 16'h0}};
`else
    vecs[5] = '{nb: 4'd5, bytes: {8'h90, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'h00}, tail_n: 4'd0,
                tail_v: 8'h00, n_we: 2'd3,
                exp_we: {8'h10, 8'hA1, 8'h11, 8'hB2, 8'h12, 8'hC3}};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst reg_addr", 32'(reg_addr), 0);
    chk("rst sdo_oe", 32'(sdo_oe), 0);
    chk("rst busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst we_re", {30'h0, reg_we, reg_re}, 0);
    chk("post_rst sdo", 32'(sdo), 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      check_frame(i, vecs[i]);
    end

    // Read 0x40 @0x03; the 16th sck rise coincides with csb rise, so that bit is not
    // taken by the responder and no third prefetch is issued
    clear_mon();
    csb = 1'b0;
    repeat (H) @(negedge clk);
    send_byte(8'h40, r);
    send_byte(8'h03, r);
    chk("rd oe_after_addr_rise", 32'(sdo_oe), 0);
    chk("rd busy_mid", 32'(busy), 1);
    for (int i = 15; i >= 1; i--) send_bit(1'b0, rx[i]);
    sdi = 1'b0;
    repeat (H) @(negedge clk);
    sck = 1'b1;
    csb = 1'b1;
    rx[0] = sdo;
    repeat (H) @(negedge clk);
    sck = 1'b0;
    repeat (8) @(negedge clk);
    chk("rd sdo_bytes", 32'(rx), 32'h115A);
    chk("rd re_count", re_a.size(), 2);
    if (re_a.size() >= 2) begin
      chk("rd re0_addr", 32'(re_a[0]), 32'h03);
      chk("rd re1_addr", 32'(re_a[1]), 32'h04);
    end
    chk("rd oe_seen", 32'(oe_seen), 1);
    chk("rd oe_after", 32'(sdo_oe), 0);
    chk("rd busy_after", 32'(busy), 0);
    chk("rd we_count", we_a.size(), 0);

    // Read-write 0xC0 @0x20: each write precedes the next read by exactly one cycle
    clear_mon();
    csb = 1'b0;
    repeat (H) @(negedge clk);
    send_byte(8'hC0, r);
    send_byte(8'h20, r);
    send_byte(8'hAB, rx[15:8]);
    send_byte(8'hCD, rx[7:0]);
    end_frame();
    chk("rw sdo_bytes", 32'(rx), {16'h0, mem_rd(8'h20), mem_rd(8'h21)});
    chk("rw we_count", we_a.size(), 2);
    chk("rw re_count", re_a.size(), 3);
    if (we_a.size() == 2 && re_a.size() == 3) begin
      chk("rw we0", {16'h0, we_a[0], we_d[0]}, 32'h20AB);
      chk("rw we1", {16'h0, we_a[1], we_d[1]}, 32'h21CD);
      chk("rw re_addrs", {8'h0, re_a[0], re_a[1], re_a[2]}, 32'h202122);
      chk("rw order0", re_c[1] - we_c[0], 1);
      chk("rw order1", re_c[2] - we_c[1], 1);
    end

    // Reset pulse during the data byte of a write frame
    clear_mon();
    csb = 1'b0;
    repeat (H) @(negedge clk);
    send_byte(8'h80, r);
    send_byte(8'h13, r);
    for (int i = 0; i < 3; i++) send_bit(1'b1, b);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst reg_addr", 32'(reg_addr), 0);
    chk("mid_rst reg_wdata", 32'(reg_wdata), 0);
    chk("mid_rst outs", {27'h0, reg_we, reg_re, sdo, sdo_oe, busy}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b0, b);
    send_byte(8'h44, r);
    end_frame();
    chk("mid_rst we_count", we_a.size(), 0);
    chk("mid_rst re_count", re_a.size(), 0);

    run_frame(vecs[3]);
    check_frame(6, vecs[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
